vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 130 +++++++++++++
 tb/tb_vga_timing.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator with pipeline-aligned sync and colour outputs
module vga_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE_LAT = 1,
    parameter int FC_MAX   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] pix_rgb_in,
    output logic [9:0]  hc,
    output logic [9:0]  vc,
    output logic        pix_ce,
    output logic        active,
    output logic        frame_start,
    output logic [5:0]  fc,
    output logic        hs,
    output logic        vs,
    output logic [11:0] vga_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [5:0]       FC_LAST  = 6'(FC_MAX);
    localparam logic             POL      = (SYNC_POL != 0);

    // 11-bit bounds so a segment end of exactly 1024 still compares correctly
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             h_last;
    logic             v_last;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             hsync_d;
    logic             vsync_d;
    logic             active_d;
    logic [10:0]      hc_x;
    logic [10:0]      vc_x;

    always_comb begin
        hc_x        = {1'b0, hc};
        vc_x        = {1'b0, vc};
        pix_ce      = en && (div == DIV_LAST);
        h_last      = (hc == H_LAST);
        v_last      = (vc == V_LAST);
        frame_start = pix_ce && h_last && v_last;
        active      = (hc_x < H_ACT_END) && (vc_x < V_ACT_END);
        hsync_raw   = (hc_x >= HS_BEG) && (hc_x < HS_END);
        vsync_raw   = (vc_x >= VS_BEG) && (vc_x < VS_END);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
            hc  <= '0;
            vc  <= '0;
            fc  <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (pix_ce) begin
                hc <= h_last ? 10'd0 : hc + 10'd1;
                if (h_last) begin
                    vc <= v_last ? 10'd0 : vc + 10'd1;
                end
            end
            if (frame_start) begin
                fc <= (fc == FC_LAST) ? 6'd0 : fc + 6'd1;
            end
        end
    end

    // Delay line matches the sync/blank timing to the pixel source latency
    generate
        if (PIPE_LAT == 0) begin : g_no_delay
            assign hsync_d  = hsync_raw;
            assign vsync_d  = vsync_raw;
            assign active_d = active;
        end else begin : g_delay
            logic [2:0] stage [PIPE_LAT];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        stage[i] <= 3'b000;
                    end
                end else begin
                    stage[0] <= {hsync_raw, vsync_raw, active};
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign {hsync_d, vsync_d, active_d} = stage[PIPE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            hs      <= ~POL;
            vs      <= ~POL;
            vga_rgb <= 12'h000;
        end else begin
            hs      <= hsync_d ? POL : ~POL;
            vs      <= vsync_d ? POL : ~POL;
            vga_rgb <= active_d ? pix_rgb_in : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing in two small configurations
module tb_vga_timing;

    typedef struct packed {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic        pix_ce;
        logic        active;
        logic        frame_start;
        logic [5:0]  fc;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, rst_b, en_b;
    logic [11:0] pix_a, pix_b;
    logic [9:0]  hc_a, vc_a, hc_b, vc_b;
    logic        pce_a, act_a, fs_a, hs_a, vs_a;
    logic        pce_b, act_b, fs_b, hs_b, vs_b;
    logic [5:0]  fc_a, fc_b;
    logic [11:0] rgb_a, rgb_b;
    obs_t        obs_a, obs_b;

    assign obs_a = {hc_a, vc_a, pce_a, act_a, fs_a, fc_a, hs_a, vs_a, rgb_a};
    assign obs_b = {hc_b, vc_b, pce_b, act_b, fs_b, fc_b, hs_b, vs_b, rgb_b};

    vga_timing #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .PIPE_LAT(2), .FC_MAX(50)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_rgb_in(pix_a),
        .hc(hc_a), .vc(vc_a), .pix_ce(pce_a), .active(act_a),
        .frame_start(fs_a), .fc(fc_a), .hs(hs_a), .vs(vs_a), .vga_rgb(rgb_a)
    );

    vga_timing #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .PIPE_LAT(1), .FC_MAX(3)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .pix_rgb_in(pix_b),
        .hc(hc_b), .vc(vc_b), .pix_ce(pce_b), .active(act_b),
        .frame_start(fs_b), .fc(fc_b), .hs(hs_b), .vs(vs_b), .vga_rgb(rgb_b)
    );

    int   checks = 0;
    int   failures = 0;
    obs_t q_a[$];
    obs_t q_b[$];

    // Model state: enabled-edge count since reset, plus a history of raw sync/active per sample
    int         m_n [2];
    int         m_k [2];
    logic [2:0] m_hist [2][32];
    logic       m_hval [2][32];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0;
            m_k[d] = 0;
            for (int i = 0; i < 32; i++) begin
                m_hist[d][i] = 3'b000;
                m_hval[d][i] = 1'b0;
            end
        end
    end

    function automatic obs_t model_step(input int id, input int D,
            input int HA, input int HF, input int HS, input int HB,
            input int VA, input int VF, input int VS, input int VB,
            input int L, input int POL, input int FCM,
            input logic r, input logic e, input logic [11:0] pix);
        obs_t o;
        int   ht, vt, j, p, h, v;
        logic pl, hraw, vraw;
        ht = HA + HF + HS + HB;
        vt = VA + VF + VS + VB;
        pl = (POL != 0);
        o.hs  = ~pl;
        o.vs  = ~pl;
        o.rgb = 12'h000;
        j = m_k[id] - 1 - L;
        if (r && j >= 0 && m_hval[id][j % 32]) begin
            o.hs  = m_hist[id][j % 32][2] ? pl : ~pl;
            o.vs  = m_hist[id][j % 32][1] ? pl : ~pl;
            o.rgb = m_hist[id][j % 32][0] ? pix : 12'h000;
        end
        if (!r) begin
            m_n[id] = 0;
            for (int i = 0; i < 32; i++) m_hval[id][i] = 1'b0;
        end else if (e) begin
            m_n[id] = m_n[id] + 1;
        end
        p = m_n[id] / D;
        h = p % ht;
        v = (p / ht) % vt;
        o.hc          = 10'(h);
        o.vc          = 10'(v);
        o.fc          = 6'((p / (ht * vt)) % (FCM + 1));
        o.pix_ce      = e && ((m_n[id] % D) == D - 1);
        o.frame_start = o.pix_ce && (h == ht - 1) && (v == vt - 1);
        o.active      = (h < HA) && (v < VA);
        hraw = (h >= HA + HF) && (h < HA + HF + HS);
        vraw = (v >= VA + VF) && (v < VA + VF + VS);
        m_hist[id][m_k[id] % 32] = {hraw, vraw, o.active};
        m_hval[id][m_k[id] % 32] = 1'b1;
        m_k[id] = m_k[id] + 1;
        return o;
    endfunction

    task automatic step(input logic ra, input logic ea, input logic rb, input logic eb);
        logic [11:0] pb;
        pb    = 12'($urandom);
        rst_a = ra; en_a = ea; pix_a = 12'hABC;
        rst_b = rb; en_b = eb; pix_b = pb;
        q_a.push_back(model_step(0, 1, 4, 1, 2, 1, 3, 1, 1, 1, 2, 1, 50, ra, ea, 12'hABC));
        q_b.push_back(model_step(1, 4, 8, 2, 3, 3, 4, 1, 2, 1, 1, 0, 3, rb, eb, pb));
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin : monitor
        obs_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                checks++;
                if (obs_a !== e) begin
                    failures++;
                    $display("FAIL scoreboard_a time=%0t actual=%h required=%h", $time, obs_a, e);
                end
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                checks++;
                if (obs_b !== e) begin
                    failures++;
                    $display("FAIL scoreboard_b time=%0t actual=%h required=%h", $time, obs_b, e);
                end
            end
        end
    end

    initial begin : driver
        int first, hc_at4, fs_seen, hs_cnt, vs_cnt, rgb_cnt, pce_cnt;
        int fs_step [3];
        int hc0, vc0, nfs, found;
        logic prev_fs, done;

        for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset_a_hs", hs_a, 0);
        chk("reset_a_vs", vs_a, 0);
        chk("reset_a_rgb", rgb_a, 0);
        chk("reset_b_hs", hs_b, 1);
        chk("reset_b_vs", vs_b, 1);
        chk("reset_b_hc", hc_b, 0);
        chk("reset_b_pix_ce", pce_b, 0);

        first = -1;
        hc_at4 = -1;
        for (int s = 1; s <= 8; s++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (pce_b && first < 0) first = s;
            if (s == 4) hc_at4 = hc_b;
        end
        chk("first_pix_ce_step_b", first, 3);
        chk("hc_after_first_pix_ce_b", hc_at4, 1);

        // One full frame of dut_a between two frame_start pulses
        fs_seen = 0; hs_cnt = 0; vs_cnt = 0; rgb_cnt = 0;
        fs_step[0] = 0; fs_step[1] = 0; fs_step[2] = 0;
        for (int s = 0; s < 200 && fs_seen < 3; s++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (fs_seen == 1) begin
                hs_cnt  += int'(hs_a);
                vs_cnt  += int'(vs_a);
                rgb_cnt += int'(rgb_a == 12'hABC);
            end
            if (fs_a) begin
                fs_step[fs_seen] = s;
                fs_seen++;
            end
        end
        chk("frame_starts_seen_a", fs_seen, 3);
        chk("frame_period_a_1", fs_step[1] - fs_step[0], 48);
        chk("frame_period_a_2", fs_step[2] - fs_step[1], 48);
        chk("hs_high_per_frame_a", hs_cnt, 12);
        chk("vs_high_per_frame_a", vs_cnt, 8);
        chk("rgb_visible_per_frame_a", rgb_cnt, 12);

        // Freeze dut_b for 10 clks right where div sits at its last value
        found = 0;
        for (int s = 0; s < 200 && found == 0; s++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (pce_b && hc_b == 10'd2) found = 1;
        end
        chk("find_hc2_b", found, 1);
        hc0 = hc_b; vc0 = vc_b; pce_cnt = 0;
        for (int s = 0; s < 10; s++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            pce_cnt += int'(pce_b);
        end
        chk("freeze_hc_b", hc_b, hc0);
        chk("freeze_vc_b", vc_b, vc0);
        chk("freeze_pix_ce_b", pce_cnt, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("resume_hc_b", hc_b, 3);

        // Mid-frame reset of dut_b with en low: reset wins
        found = 0;
        for (int s = 0; s < 700 && found == 0; s++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (vc_b == 10'd2 && hc_b == 10'd5) found = 1;
        end
        chk("find_mid_frame_b", found, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midreset_hc_b", hc_b, 0);
        chk("midreset_vc_b", vc_b, 0);
        chk("midreset_fc_b", fc_b, 0);
        chk("midreset_hs_b", hs_b, 1);
        chk("midreset_vs_b", vs_b, 1);
        chk("midreset_rgb_b", rgb_b, 0);

        // Frame counter of dut_a through 51 frames from reset
        step(1'b0, 1'b1, 1'b1, 1'b1);
        nfs = 0; prev_fs = 1'b0; done = 1'b0;
        for (int s = 0; s < 2600 && !done; s++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (prev_fs && nfs == 1) chk("fc_after_1st_frame_a", fc_a, 1);
            if (prev_fs && nfs == 50) chk("fc_after_50th_frame_a", fc_a, 50);
            if (prev_fs && nfs == 51) begin
                chk("fc_wrap_after_51st_frame_a", fc_a, 0);
                done = 1'b1;
            end
            if (fs_a) nfs++;
            prev_fs = fs_a;
        end
        chk("fc_wrap_reached_a", int'(done), 1);

        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("queue_drained_a", q_a.size(), 0);
        chk("queue_drained_b", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
